// File: rtl/pp_drive_ctrl.sv
// Break-before-make driver-enable controller for a push-pull/open-drain line buffer.
// Turns a requested level and mode into registered pull-up/pull-down enables with programmable dead time.

module pp_drive_ctrl_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic pu_i,
    input logic pd_i,
    input logic busy_i
);

    // Both enables together would short the supply; this must never be seen, reset included.
    a_no_shoot_through: assert property (@(posedge clk_i) !(pu_i && pd_i));

    a_dead_released: assert property (@(posedge clk_i) disable iff (!rst_ni)
        busy_i |-> (!pu_i && !pd_i));

endmodule

module pp_drive_ctrl #(
    parameter int DeadCntWidth = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    drive_en_i,
    input  logic                    od_mode_i,
    input  logic                    data_i,
    input  logic [DeadCntWidth-1:0] t_dead_i,
    output logic                    pull_up_en_o,
    output logic                    pull_down_en_o,
    output logic                    busy_o,
    output logic                    state_chg_o
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_HIGH = 2'b01,
        ST_LOW  = 2'b10,
        ST_DEAD = 2'b11
    } state_e;

    state_e                  state_q;
    state_e                  state_d;
    state_e                  target_s;
    logic [DeadCntWidth-1:0] cnt_q;
    logic [DeadCntWidth-1:0] cnt_d;
    logic [1:0]              drv_d;
    logic                    pu_q;
    logic                    pd_q;
    logic                    busy_q;
    logic                    chg_q;

    // Returns {pull_up, pull_down}; only the two driven states ever enable a transistor.
    function automatic logic [1:0] drive_decode(input state_e st);
        logic [1:0] res;
        case (st)
            ST_OFF:  res = 2'b00;
            ST_HIGH: res = 2'b10;
            ST_LOW:  res = 2'b01;
            ST_DEAD: res = 2'b00;
            default: res = 2'b00;
        endcase
        return res;
    endfunction

    // Target level from the current request; open-drain produces a high by releasing.
    always_comb begin
        target_s = ST_OFF;
        if (!drive_en_i) begin
            target_s = ST_OFF;
        end else if (!data_i) begin
            target_s = ST_LOW;
        end else if (od_mode_i) begin
            target_s = ST_OFF;
        end else begin
            target_s = ST_HIGH;
        end
    end

    // Next-state and dead-time counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                state_d = target_s;
                cnt_d   = '0;
            end
            ST_HIGH: begin
                if (target_s == ST_LOW) begin
                    state_d = ST_DEAD;
                    cnt_d   = t_dead_i;
                end else if (target_s == ST_OFF) begin
                    state_d = ST_OFF;
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (target_s == ST_HIGH) begin
                    state_d = ST_DEAD;
                    cnt_d   = t_dead_i;
                end else if (target_s == ST_OFF) begin
                    state_d = ST_OFF;
                end else begin
                    state_d = ST_LOW;
                end
            end
            ST_DEAD: begin
                // Exit level is re-evaluated on the final cycle, so a mid-dead toggle just changes where we land.
                if (target_s == ST_OFF) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    state_d = ST_DEAD;
                    cnt_d   = cnt_q - DeadCntWidth'(1);
                end else begin
                    state_d = target_s;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    assign drv_d = drive_decode(state_d);

    // State, counter and outputs all update on the same edge so enables track the state register exactly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            pu_q    <= 1'b0;
            pd_q    <= 1'b0;
            busy_q  <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pu_q    <= drv_d[1];
            pd_q    <= drv_d[0];
            busy_q  <= (state_d == ST_DEAD);
            chg_q   <= (state_d != state_q);
        end
    end

    assign pull_up_en_o   = pu_q;
    assign pull_down_en_o = pd_q;
    assign busy_o         = busy_q;
    assign state_chg_o    = chg_q;

    pp_drive_ctrl_chk u_chk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .pu_i   (pu_q),
        .pd_i   (pd_q),
        .busy_i (busy_q)
    );

endmodule

// File: doc/pp_drive_ctrl.md
Name: pp_drive_ctrl

Overview:
Sequential driver-enable controller that sits directly upstream of the push-pull output buffer model. It converts a requested line level and drive mode into registered pull_up_en/pull_down_en controls. It guarantees that both controls are never asserted together, and it inserts a programmable break-before-make dead time on every HIGH<->LOW reversal. It serves both open-drain mode (only pull-down is used) and push-pull mode on SDA/SCL.

Parameters:
DeadCntWidth, 4, width of the dead-time count input and the internal dead-time counter.

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
drive_en_i  input  1  1: block may drive the line; 0: release the line (both enables low)
od_mode_i  input  1  1: open-drain (a high level is produced by releasing the line); 0: push-pull
data_i  input  1  requested line level
t_dead_i  input  DeadCntWidth  extra dead-time cycles inserted on a HIGH<->LOW reversal
pull_up_en_o  output  1  to buffer pull_up_en
pull_down_en_o  output  1  to buffer pull_down_en
busy_o  output  1  high while in DEAD
state_chg_o  output  1  one-cycle pulse on the cycle after the state register changes value

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values: state=OFF, pull_up_en_o=0, pull_down_en_o=0, busy_o=0, state_chg_o=0, counter=0.
- Target level, computed combinationally each cycle:
  - !drive_en_i -> OFF
  - data_i=0 -> LOW
  - data_i=1 and od_mode_i=1 -> OFF
  - otherwise -> HIGH
- Output decode, registered from state:
  - OFF: pu=0, pd=0
  - HIGH: pu=1, pd=0
  - LOW: pu=0, pd=1
  - DEAD: pu=0, pd=0
  - The combination pu=1, pd=1 is unreachable. Verification asserts this every cycle, including reset exit.
- Latency: an input change is reflected on the outputs one clock edge later, except when the change passes through DEAD.
- Transitions:
  - OFF -> HIGH or LOW directly when the target is HIGH or LOW. No dead time, because the line is already released.
  - HIGH -> OFF and LOW -> OFF directly when the target is OFF.
  - HIGH -> DEAD when the target is LOW; LOW -> DEAD when the target is HIGH. On entry the counter is loaded with t_dead_i.
  - DEAD, target OFF: go to OFF immediately and clear the counter.
  - DEAD, counter != 0: decrement and stay.
  - DEAD, counter == 0: go to the current target (re-evaluated that cycle; it may be the original level).
  - DEAD therefore lasts t_dead_i+1 cycles. With t_dead_i=0, dead time is exactly 1 cycle.
  - Target equal to the current driven state: hold, no pulse.
- t_dead_i is sampled only at DEAD entry. Changes during DEAD have no effect on the running count.
- Target toggling during DEAD does not restart the count. The exit level is whatever the target is on the exit cycle.
- od_mode_i rising while in HIGH: the target becomes OFF, so the next state is OFF (pull-up released with no dead time).
- busy_o = (state == DEAD), registered alongside the outputs.
- state_chg_o: 1 on the cycle after any state register update to a different value; 0 otherwise.
- Reset asserted mid-DEAD or mid-drive: all outputs go to 0 asynchronously and the counter clears. After deassertion the FSM starts from OFF.

Test Plan:
1. Reset release with drive_en_i=1, od_mode_i=0, data_i=1 -> cycle after first edge pu=1, pd=0, state_chg_o pulse; pu and pd never both 1 during reset exit.
2. Push-pull, t_dead_i=3, data_i toggles 1->0 while HIGH -> pu=0, pd=0 for exactly 4 cycles with busy_o=1, then pd=1; pu&pd never 1.
3. Open-drain, data_i sequence 0,1,0 -> pd=1, then pu=0/pd=0, then pd=1; pu stays 0 throughout; no DEAD state entered.
4. t_dead_i=0 reversal LOW->HIGH -> exactly one cycle with both enables 0, then pu=1.
5. In DEAD with t_dead_i=5: toggle data_i back to 1 at count 2, then deassert drive_en_i -> first toggle does not restart the count and the exit level follows the target; after the drive_en_i deassertion the next state is OFF, busy_o drops, pu=pd=0.
6. Assert rst_ni=0 asynchronously mid-DEAD (between clock edges) -> outputs are 0 immediately, before the next edge; after release, state is OFF and the reversal restarts cleanly with a full dead time.
